// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, captures the combinational
// instruction-memory word into the IF/ID register with its PC and PC+4, and
// applies redirect / stall / flush. Also counts valid instructions fetched.
module fetch_stage #(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter logic [W-1:0] NOP      = 32'h0000_0013,
  parameter int           CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             branch_taken_i,
  input  logic [W-1:0]     branch_target_i,
  input  logic [W-1:0]     instruction_i,
  output logic [W-1:0]     pc_o,
  output logic [W-1:0]     if_id_instr_o,
  output logic [W-1:0]     if_id_pc_o,
  output logic [W-1:0]     if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic             misaligned_o,
  output logic [CNT_W-1:0] fetch_count_o
);

  logic [W-1:0]     r_pc;
  logic [W-1:0]     r_instr;
  logic [W-1:0]     r_if_pc;
  logic [W-1:0]     r_if_pc4;
  logic             r_valid;
  logic             r_misaligned;
  logic [CNT_W-1:0] r_count;

  logic [W-1:0]     w_pc4;
  logic [W-1:0]     w_target;
  logic             w_load_valid;

  // Sequential PC increment wraps naturally at 2^W.
  assign w_pc4    = r_pc + W'(4);
  // Redirect target is forced onto a word boundary.
  assign w_target = {branch_target_i[W-1:2], 2'b00};
  // A real instruction enters IF/ID only on a plain advance.
  assign w_load_valid = !branch_taken_i && !stall_i && !flush_i;

  // PC, IF/ID register and misalignment pulse; redirect > stall > flush > advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_instr      <= NOP;
      r_if_pc      <= '0;
      r_if_pc4     <= '0;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (branch_taken_i) begin
      r_pc         <= w_target;
      r_instr      <= NOP;
      r_if_pc      <= '0;
      r_if_pc4     <= '0;
      r_valid      <= 1'b0;
      r_misaligned <= |branch_target_i[1:0];
    end else if (stall_i) begin
      r_misaligned <= 1'b0;
      // A flush during a stall still kills the held entry; PC stays put.
      if (flush_i) begin
        r_instr  <= NOP;
        r_if_pc  <= '0;
        r_if_pc4 <= '0;
        r_valid  <= 1'b0;
      end
    end else if (flush_i) begin
      r_pc         <= w_pc4;
      r_instr      <= NOP;
      r_if_pc      <= '0;
      r_if_pc4     <= '0;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_pc4;
      r_instr      <= instruction_i;
      r_if_pc      <= r_pc;
      r_if_pc4     <= w_pc4;
      r_valid      <= 1'b1;
      r_misaligned <= 1'b0;
    end
  end

  // Saturating count of valid instructions loaded into IF/ID.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_load_valid && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign pc_o          = r_pc;
  assign if_id_instr_o = r_instr;
  assign if_id_pc_o    = r_if_pc;
  assign if_id_pc4_o   = r_if_pc4;
  assign if_id_valid_o = r_valid;
  assign misaligned_o  = r_misaligned;
  assign fetch_count_o = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each directed vector pushes its hand-computed
// post-edge outputs into a queue; a monitor pops and compares after every edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] instruction_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic        misaligned_o;
  logic [31:0] fetch_count_o;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        v;
    logic        m;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_pass;
  bit   stim_done;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .instruction_i   (instruction_i),
    .pc_o            (pc_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_pc_o      (if_id_pc_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_valid_o   (if_id_valid_o),
    .misaligned_o    (misaligned_o),
    .fetch_count_o   (fetch_count_o)
  );

  // Instruction memory preloaded so that word i holds value i.
  assign instruction_i = {2'b00, pc_o[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s actual=%h expected=%h", tag, field, act, exp);
  endtask

  // Monitor: one comparison set per clock edge that has a pending expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      $display("txn %-10s pc=%h instr=%h ipc=%h ipc4=%h v=%0b mis=%0b cnt=%0d",
               e.name, pc_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o,
               if_id_valid_o, misaligned_o, fetch_count_o);
      chk(e.name, "pc",    pc_o,                  e.pc);
      chk(e.name, "instr", if_id_instr_o,         e.instr);
      chk(e.name, "ipc",   if_id_pc_o,            e.ipc);
      chk(e.name, "ipc4",  if_id_pc4_o,           e.ipc4);
      chk(e.name, "valid", {31'd0, if_id_valid_o}, {31'd0, e.v});
      chk(e.name, "mis",   {31'd0, misaligned_o},  {31'd0, e.m});
      chk(e.name, "cnt",   fetch_count_o,         e.cnt);
    end
  end

  // Apply one vector before the edge and queue the outputs expected after it.
  task automatic step(input string name, input logic rst, input logic st,
                      input logic fl, input logic br, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_ipc, input logic [31:0] e_ipc4,
                      input logic e_v, input logic e_m, input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst_n           = rst;
    stall_i         = st;
    flush_i         = fl;
    branch_taken_i  = br;
    branch_target_i = tgt;
    e.name = name; e.pc = e_pc; e.instr = e_instr; e.ipc = e_ipc; e.ipc4 = e_ipc4;
    e.v = e_v; e.m = e_m; e.cnt = e_cnt;
    q.push_back(e);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; stim_done = 0;
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = '0;

    // Reset for two edges, then free run eight edges.
    step("rst0",   0,0,0,0,0, 32'h0, 32'h13, 0, 0, 0,0, 0);
    step("rst1",   0,0,0,0,0, 32'h0, 32'h13, 0, 0, 0,0, 0);
    for (int k = 1; k <= 8; k++)
      step("run", 1,0,0,0,0, 32'(4*k), 32'(k-1), 32'(4*(k-1)), 32'(4*k), 1,0, 32'(k));

    // Re-reset, advance to pc 8, stall three edges, release.
    step("rst2",   0,0,0,0,0, 32'h0, 32'h13, 0, 0, 0,0, 0);
    step("adv1",   1,0,0,0,0, 32'h4, 32'h0, 32'h0, 32'h4, 1,0, 1);
    step("adv2",   1,0,0,0,0, 32'h8, 32'h1, 32'h4, 32'h8, 1,0, 2);
    for (int k = 0; k < 3; k++)
      step("stall", 1,1,0,0,0, 32'h8, 32'h1, 32'h4, 32'h8, 1,0, 2);
    step("release",1,0,0,0,0, 32'hC, 32'h2, 32'h8, 32'hC, 1,0, 3);

    // Stall+flush bubbles while PC holds; flush alone advances PC.
    step("stflush",1,1,1,0,0, 32'hC, 32'h13, 0, 0, 0,0, 3);
    step("sthold", 1,1,0,0,0, 32'hC, 32'h13, 0, 0, 0,0, 3);
    step("flush",  1,0,1,0,0, 32'h10, 32'h13, 0, 0, 0,0, 3);
    step("adv3",   1,0,0,0,0, 32'h14, 32'h4, 32'h10, 32'h14, 1,0, 4);

    // Branch wins over a simultaneous stall.
    step("brstall",1,1,0,1,32'h40, 32'h40, 32'h13, 0, 0, 0,0, 4);
    step("adv4",   1,0,0,0,0, 32'h44, 32'h10, 32'h40, 32'h44, 1,0, 5);

    // Misaligned target: aligned PC and a one-cycle pulse.
    step("brmis",  1,0,1,1,32'h42, 32'h40, 32'h13, 0, 0, 0,1, 5);
    step("adv5",   1,0,0,0,0, 32'h44, 32'h10, 32'h40, 32'h44, 1,0, 6);

    // Branch to top word, then PC wraps to zero.
    step("brtop",  1,0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h13, 0, 0, 0,0, 6);
    step("wrap",   1,0,0,0,0, 32'h0, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1,0, 7);
    step("adv6",   1,0,0,0,0, 32'h4, 32'h0, 32'h0, 32'h4, 1,0, 8);

    // Reset beats flush and branch on the same edge.
    step("rstmid", 0,0,1,1,32'h42, 32'h0, 32'h13, 0, 0, 0,0, 0);
    step("adv7",   1,0,0,0,0, 32'h4, 32'h0, 32'h0, 32'h4, 1,0, 1);

    stim_done = 1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    int waited;
    waited = 0;
    wait (stim_done);
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
